// File: rtl/snake_engine.sv
`default_nettype none
// ============================================================================
// Module   : snake_engine
// Brief    : Snake game core on a 2^COL_BITS x 2^ROW_BITS grid. Keeps the
//            body, food, heading and game state, moves one cell per Tick,
//            detects wall/self collisions and places food on free cells.
// Revision : 1.0 - initial release
// ============================================================================
module snake_engine #(
    parameter  int                             COL_BITS  = 4,
    parameter  int                             ROW_BITS  = 4,
    parameter  int                             MAX_LEN   = 16,
    parameter  logic [COL_BITS+ROW_BITS-1:0]   START_LOC = 8'h7D,
    localparam int                             LOC_W     = COL_BITS + ROW_BITS,
    localparam int                             LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Left,
    input  logic                     Right,
    input  logic                     Up,
    input  logic                     Down,
    input  logic                     Ack,
    input  logic                     Tick,
    output logic                     Qi,
    output logic                     Qw,
    output logic                     Qm,
    output logic                     Qc,
    output logic                     Qp,
    output logic                     Qv,
    output logic                     Ql,
    output logic [LOC_W-1:0]         Food,
    output logic [LEN_W-1:0]         Length,
    output logic [MAX_LEN*LOC_W-1:0] Locations_Flat
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_MOVE  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_PLACE = 3'd4;
    localparam logic [2:0] S_WIN   = 3'd5;
    localparam logic [2:0] S_LOSE  = 3'd6;

    // Opposite directions differ only in bit 0.
    localparam logic [1:0] D_LEFT  = 2'd0;
    localparam logic [1:0] D_RIGHT = 2'd1;
    localparam logic [1:0] D_UP    = 2'd2;
    localparam logic [1:0] D_DOWN  = 2'd3;

    localparam logic [COL_BITS-1:0] COL_ONE = 1;
    localparam logic [COL_BITS-1:0] COL_MAX = '1;
    localparam logic [ROW_BITS-1:0] ROW_ONE = 1;
    localparam logic [ROW_BITS-1:0] ROW_MAX = '1;
    localparam logic [LOC_W-1:0]    LOC_ONE = 1;
    localparam logic [LEN_W-1:0]    LEN_ONE = 1;

    // Galois feedback masks (right-shifting form) for maximal-length LFSRs.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            2:       lfsr_taps = 32'h0003;
            3:       lfsr_taps = 32'h0006;
            4:       lfsr_taps = 32'h000C;
            5:       lfsr_taps = 32'h0014;
            6:       lfsr_taps = 32'h0030;
            7:       lfsr_taps = 32'h0060;
            8:       lfsr_taps = 32'h00B8;
            9:       lfsr_taps = 32'h0110;
            10:      lfsr_taps = 32'h0240;
            11:      lfsr_taps = 32'h0500;
            12:      lfsr_taps = 32'h0829;
            13:      lfsr_taps = 32'h100D;
            14:      lfsr_taps = 32'h2015;
            15:      lfsr_taps = 32'h6000;
            default: lfsr_taps = 32'hD008;
        endcase
    endfunction

    localparam logic [LOC_W-1:0] LFSR_TAPS = LOC_W'(lfsr_taps(LOC_W));

    logic [2:0]          state;
    logic [2:0]          state_next;
    logic [LOC_W-1:0]    seg [MAX_LEN];
    logic [LEN_W-1:0]    length;
    logic [LOC_W-1:0]    food;
    logic [LOC_W-1:0]    cand;
    logic [LOC_W-1:0]    lfsr;
    logic [LOC_W-1:0]    lfsr_next;
    logic [1:0]          dir;
    logic [1:0]          pend;
    logic                req_valid;
    logic [1:0]          req_dir;
    logic [ROW_BITS-1:0] head_row;
    logic [COL_BITS-1:0] head_col;
    logic [LOC_W-1:0]    head_next;
    logic                wall_hit;
    logic [MAX_LEN-1:0]  self_vec;
    logic [MAX_LEN-1:0]  occ_vec;
    logic                self_hit;
    logic                occupied;
    logic                eat;
    logic [LEN_W-1:0]    len_inc;
    logic                win_len;

    assign head_row  = seg[0][LOC_W-1:COL_BITS];
    assign head_col  = seg[0][COL_BITS-1:0];
    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    assign self_hit  = |self_vec;
    assign occupied  = |occ_vec;
    assign eat       = (seg[0] == food);
    assign len_inc   = length + LEN_ONE;
    assign win_len   = (len_inc == LEN_W'(MAX_LEN));
    assign Food      = food;
    assign Length    = length;

    // Per-segment comparators, masked to the valid part of the body.
    // Segment 0 is the head itself and never counts as a self hit.
    generate
        for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
            if (i == 0) begin : g_head
                assign self_vec[i] = 1'b0;
            end else begin : g_body
                assign self_vec[i] = (seg[i] == seg[0]) && (LEN_W'(i) < length);
            end
            assign occ_vec[i] = (seg[i] == cand) && (LEN_W'(i) < length);
            assign Locations_Flat[(MAX_LEN-1-i)*LOC_W +: LOC_W] = seg[i];
        end
    endgenerate

    // Direction request priority: Left > Right > Up > Down.
    always_comb begin
        req_valid = 1'b1;
        req_dir   = D_LEFT;
        if (Left)       req_dir = D_LEFT;
        else if (Right) req_dir = D_RIGHT;
        else if (Up)    req_dir = D_UP;
        else if (Down)  req_dir = D_DOWN;
        else            req_valid = 1'b0;
    end

    // Candidate head one cell along the pending heading; edges are walls.
    always_comb begin
        head_next = seg[0];
        wall_hit  = 1'b0;
        case (pend)
            D_LEFT:  if (head_col == '0)    wall_hit = 1'b1;
                     else head_next = {head_row, head_col - COL_ONE};
            D_RIGHT: if (head_col == COL_MAX) wall_hit = 1'b1;
                     else head_next = {head_row, head_col + COL_ONE};
            D_UP:    if (head_row == '0)    wall_hit = 1'b1;
                     else head_next = {head_row - ROW_ONE, head_col};
            default: if (head_row == ROW_MAX) wall_hit = 1'b1;
                     else head_next = {head_row + ROW_ONE, head_col};
        endcase
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_INIT;
        else       state <= state_next;
    end

    // Next-state logic; unused encodings recover to INIT.
    always_comb begin
        state_next = state;
        case (state)
            S_INIT:  if (Ack)  state_next = S_PLACE;
            S_WAIT:  if (Tick) state_next = S_MOVE;
            S_MOVE:  state_next = wall_hit ? S_LOSE : S_CHECK;
            S_CHECK: begin
                if (self_hit)  state_next = S_LOSE;
                else if (eat)  state_next = win_len ? S_WIN : S_PLACE;
                else           state_next = S_WAIT;
            end
            S_PLACE: if (!occupied) state_next = S_WAIT;
            S_WIN,
            S_LOSE:  if (Ack)  state_next = S_INIT;
            default: state_next = S_INIT;
        endcase
    end

    // One-hot state outputs.
    always_comb begin
        {Qi, Qw, Qm, Qc, Qp, Qv, Ql} = 7'b0;
        case (state)
            S_INIT:  Qi = 1'b1;
            S_WAIT:  Qw = 1'b1;
            S_MOVE:  Qm = 1'b1;
            S_CHECK: Qc = 1'b1;
            S_PLACE: Qp = 1'b1;
            S_WIN:   Qv = 1'b1;
            S_LOSE:  Ql = 1'b1;
            default: ;
        endcase
    end

    // Datapath: body, length, food, heading, placement candidate and LFSR.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < MAX_LEN; i++) seg[i] <= '0;
            length <= '0;
            food   <= '0;
            cand   <= '0;
            lfsr   <= LOC_ONE;
            dir    <= D_RIGHT;
            pend   <= D_RIGHT;
        end else begin
            lfsr <= lfsr_next;
            // Reversal requests are judged against the heading in force.
            if (state == S_INIT)
                pend <= D_RIGHT;
            else if (req_valid && (req_dir != (dir ^ 2'b01)))
                pend <= req_dir;
            case (state)
                S_INIT: begin
                    seg[0] <= START_LOC;
                    seg[1] <= START_LOC - LOC_ONE;
                    length <= LEN_W'(2);
                    dir    <= D_RIGHT;
                    if (Ack) cand <= START_LOC + LOC_ONE;
                end
                S_MOVE: begin
                    dir <= pend;
                    if (!wall_hit) begin
                        for (int i = MAX_LEN - 1; i > 0; i--) seg[i] <= seg[i-1];
                        seg[0] <= head_next;
                    end
                end
                S_CHECK: begin
                    // Growing re-validates the old tail, already shifted in place.
                    if (!self_hit && eat) begin
                        length <= len_inc;
                        if (!win_len) cand <= lfsr;
                    end
                end
                S_PLACE: begin
                    if (occupied) cand <= cand + LOC_ONE;
                    else          food <= cand;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
